ex_stage_register: RTL
======================

EX_STAGE_REGISTER -- requirements
Module: ex_stage_register

Interface
REQ-001 clk  in  1  single clock; all state updates on the rising edge.
REQ-002 rst_n  in  1  reset, asynchronous assertion, active-low.
REQ-003 stall  in  1  hold all EX-side state for this cycle.
REQ-004 flush  in  1  load a bubble into EX (branch taken / hazard squash).
REQ-005 id_instruction  in  32  decoded instruction word from the ID stage.
REQ-006 id_pc  in  32  PC of id_instruction.
REQ-007 id_rn_data, id_rm_data  in  32 each  register file read operands.
REQ-008 id_rd_addr  in  4  destination register index (instruction[15:12]).
REQ-009 id_reg_write_enable, id_mem_enable, id_mem_rw, id_mem_to_reg_select, id_alu_source_select, id_status_bit, id_pc_source_select, id_mem_size  in  1 each  control-unit outputs.
REQ-010 id_alu_operation  in  4  control-unit ALU opcode.
REQ-011 cpsr_flags  in  4  current N,Z,C,V flags (bit 3 = N, bit 0 = V).
REQ-012 ex_* outputs  out  same widths  registered copies of every REQ-005..REQ-010 input (id_ prefix replaced by ex_).
REQ-013 ex_valid  out  1  EX holds a real, non-squashed instruction.
REQ-014 ex_cond_pass  out  1  registered condition-check result for the EX instruction.

Function
REQ-015 Priority each rising edge SHALL be: flush > stall > normal load.
REQ-016 Normal load SHALL capture all id_* inputs into ex_* with exactly one cycle latency.
REQ-017 Flush SHALL clear every ex_* control output, ex_instruction, ex_valid and ex_cond_pass to 0; data/PC/rd outputs SHALL also clear to 0.
REQ-018 Stall (without flush) SHALL hold every output at its current value, including ex_valid.
REQ-019 Flush and stall asserted together SHALL produce the flush result.
REQ-020 id_instruction == 32'h0 on a normal load SHALL be captured as a bubble: ex_valid=0, all ex_ control outputs 0, ex_cond_pass=0.
REQ-021 Any other loaded instruction SHALL set ex_valid=1.
REQ-022 Control gating: when the loaded instruction fails its condition (REQ-027), the seven write/side-effect controls (reg_write_enable, mem_enable, mem_rw, status_bit, pc_source_select, mem_to_reg_select, mem_size) SHALL load as 0 and ex_valid SHALL load as 0; data fields load normally.
REQ-023 ex_alu_operation and ex_alu_source_select SHALL load unchanged regardless of condition result.
REQ-024 No combinational path SHALL exist from any input to any output.
REQ-025 stall/flush held for N consecutive cycles SHALL have the same effect as one cycle (idempotent).

Reset
REQ-026 rst_n low SHALL immediately clear every output to 0 (ex_valid=0, ex_cond_pass=0), independent of clk; first load occurs on the first rising edge with rst_n high.
REQ-026a Reset asserted mid-stall or mid-flush SHALL override both; deassertion SHALL resume normal REQ-015 priority.

Configuration
REQ-027 With COND_EVAL_EN defined, the block SHALL evaluate id_instruction[31:28] against cpsr_flags at load time: EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V; HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V); AL 1; 4'b1111 0 (never).
REQ-028 With COND_EVAL_EN defined, ex_cond_pass SHALL load the REQ-027 result and REQ-022 gating SHALL apply.
REQ-029 Without COND_EVAL_EN, cpsr_flags SHALL be ignored, ex_cond_pass SHALL load 1 for every non-bubble load, and REQ-022 gating SHALL never occur.

Verification
REQ-030 Reset: rst_n=0 mid-cycle with nonzero outputs -> all outputs 0 before next clk edge.
REQ-031 Pass-through: id_instruction=32'hE0812003, reg_write_enable=1, alu_operation=4'b0100, no stall/flush -> next cycle ex_instruction=32'hE0812003, ex_reg_write_enable=1, ex_alu_operation=4'b0100, ex_valid=1.
REQ-032 Stall then flush: load 32'hE5912000 (mem_enable=1), stall 3 cycles with changing id_* -> outputs unchanged; then stall=1 and flush=1 -> ex_valid=0, ex_mem_enable=0, ex_instruction=0.
REQ-033 NOP: id_instruction=32'h0 with id_reg_write_enable forced 1 -> ex_valid=0, ex_reg_write_enable=0.
REQ-034 Condition (COND_EVAL_EN): id_instruction=32'h00812003 (EQ), reg_write_enable=1, cpsr_flags=4'b0000 -> ex_reg_write_enable=0, ex_valid=0, ex_cond_pass=0; repeat with cpsr_flags=4'b0100 -> ex_reg_write_enable=1, ex_cond_pass=1.
REQ-035 Same stimulus as REQ-034 without COND_EVAL_EN -> ex_reg_write_enable=1, ex_cond_pass=1 for both flag values.

Source files
------------

// File: rtl/ex_stage_register.sv
// ID/EX pipeline register with flush/stall priority and bubble capture.
// Optional condition evaluation against CPSR flags: define COND_EVAL_EN.
module ex_stage_register (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] id_instruction,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_rn_data,
  input  logic [31:0] id_rm_data,
  input  logic [3:0]  id_rd_addr,
  input  logic        id_reg_write_enable,
  input  logic        id_mem_enable,
  input  logic        id_mem_rw,
  input  logic        id_mem_to_reg_select,
  input  logic        id_alu_source_select,
  input  logic        id_status_bit,
  input  logic        id_pc_source_select,
  input  logic        id_mem_size,
  input  logic [3:0]  id_alu_operation,
  input  logic [3:0]  cpsr_flags,
  output logic [31:0] ex_instruction,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_rn_data,
  output logic [31:0] ex_rm_data,
  output logic [3:0]  ex_rd_addr,
  output logic        ex_reg_write_enable,
  output logic        ex_mem_enable,
  output logic        ex_mem_rw,
  output logic        ex_mem_to_reg_select,
  output logic        ex_alu_source_select,
  output logic        ex_status_bit,
  output logic        ex_pc_source_select,
  output logic        ex_mem_size,
  output logic [3:0]  ex_alu_operation,
  output logic        ex_valid,
  output logic        ex_cond_pass
);

  logic w_bubble;
  logic w_cond;
  logic w_keep;

  assign w_bubble = (id_instruction == 32'h0);

`ifdef COND_EVAL_EN
  logic w_n, w_z, w_c, w_v;
  assign {w_n, w_z, w_c, w_v} = cpsr_flags;

  always_comb begin
    w_cond = 1'b0;
    unique case (id_instruction[31:28])
      4'h0: w_cond = w_z;
      4'h1: w_cond = !w_z;
      4'h2: w_cond = w_c;
      4'h3: w_cond = !w_c;
      4'h4: w_cond = w_n;
      4'h5: w_cond = !w_n;
      4'h6: w_cond = w_v;
      4'h7: w_cond = !w_v;
      4'h8: w_cond = w_c && !w_z;
      4'h9: w_cond = !w_c || w_z;
      4'hA: w_cond = (w_n == w_v);
      4'hB: w_cond = (w_n != w_v);
      4'hC: w_cond = !w_z && (w_n == w_v);
      4'hD: w_cond = w_z || (w_n != w_v);
      4'hE: w_cond = 1'b1;
      4'hF: w_cond = 1'b0;
    endcase
  end
`else
  logic w_unused_cpsr;
  assign w_unused_cpsr = ^cpsr_flags;
  assign w_cond = 1'b1;
`endif

  // Side-effect controls survive only for a real instruction that passes.
  assign w_keep = !w_bubble && w_cond;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_instruction       <= '0;
      ex_pc                <= '0;
      ex_rn_data           <= '0;
      ex_rm_data           <= '0;
      ex_rd_addr           <= '0;
      ex_reg_write_enable  <= 1'b0;
      ex_mem_enable        <= 1'b0;
      ex_mem_rw            <= 1'b0;
      ex_mem_to_reg_select <= 1'b0;
      ex_alu_source_select <= 1'b0;
      ex_status_bit        <= 1'b0;
      ex_pc_source_select  <= 1'b0;
      ex_mem_size          <= 1'b0;
      ex_alu_operation     <= '0;
      ex_valid             <= 1'b0;
      ex_cond_pass         <= 1'b0;
    end else if (flush) begin
      ex_instruction       <= '0;
      ex_pc                <= '0;
      ex_rn_data           <= '0;
      ex_rm_data           <= '0;
      ex_rd_addr           <= '0;
      ex_reg_write_enable  <= 1'b0;
      ex_mem_enable        <= 1'b0;
      ex_mem_rw            <= 1'b0;
      ex_mem_to_reg_select <= 1'b0;
      ex_alu_source_select <= 1'b0;
      ex_status_bit        <= 1'b0;
      ex_pc_source_select  <= 1'b0;
      ex_mem_size          <= 1'b0;
      ex_alu_operation     <= '0;
      ex_valid             <= 1'b0;
      ex_cond_pass         <= 1'b0;
    end else if (!stall) begin
      ex_instruction       <= id_instruction;
      ex_pc                <= id_pc;
      ex_rn_data           <= id_rn_data;
      ex_rm_data           <= id_rm_data;
      ex_rd_addr           <= id_rd_addr;
      ex_reg_write_enable  <= id_reg_write_enable && w_keep;
      ex_mem_enable        <= id_mem_enable && w_keep;
      ex_mem_rw            <= id_mem_rw && w_keep;
      ex_mem_to_reg_select <= id_mem_to_reg_select && w_keep;
      ex_status_bit        <= id_status_bit && w_keep;
      ex_pc_source_select  <= id_pc_source_select && w_keep;
      ex_mem_size          <= id_mem_size && w_keep;
      ex_alu_source_select <= id_alu_source_select && !w_bubble;
      ex_alu_operation     <= w_bubble ? 4'h0 : id_alu_operation;
      ex_valid             <= w_keep;
      ex_cond_pass         <= w_keep;
    end
  end

endmodule
